pll_reset_ctrl: RTL and testbench
=================================

// Module: pll_reset_ctrl
// PURPOSE
// Drives the system PLL's reset input and consumes its lock output, one level above the PLL wrapper.
// Sequences PLL reset, waits for a stable lock, then holds the system reset for a fixed window before releasing the design.
// Monitors lock continuously; any loss of lock or a lock timeout restarts the sequence.
// Clocked from the free-running board reference clock, never from a PLL output.
// PARAMETERS
// PLL_RST_CYCLES      16         cycles pll_rst is held high per PLL reset attempt (>=1)
// LOCK_STABLE_CYCLES  1024       consecutive synchronized-locked cycles required before lock is accepted (>=1)
// LOCK_TIMEOUT        1000000    cycles in WAIT_LOCK before the PLL is re-reset (> LOCK_STABLE_CYCLES)
// SYS_RST_CYCLES      64         cycles sys_reset stays high after lock is accepted (>=1)
// SYNC_STAGES         2          flops in the pll_locked synchronizer (>=2)
// PORTS
// clk            in   1  board reference clock
// reset          in   1  synchronous, active-high
// pll_locked     in   1  PLL lock indicator; asynchronous to clk
// pll_rst        out  1  PLL reset request, active-high
// sys_reset      out  1  system reset, active-high; synchronous to clk
// running        out  1  high only in RUN
// lock_loss_cnt  out  8  saturating count of lock losses and timeouts since reset
// BEHAVIOUR
// - All outputs are registered. While reset is high: state=PLL_RESET; pll_rst=1, sys_reset=1, running=0, lock_loss_cnt=0; all counters and sync flops are 0.
// - pll_locked passes through a SYNC_STAGES flop chain to produce locked_s. FSM logic uses only locked_s.
// - One cycle counter, width $clog2(max param+1), is cleared on every state entry.
// - PLL_RESET: pll_rst=1, sys_reset=1. After exactly PLL_RST_CYCLES cycles in this state -> WAIT_LOCK.
// - WAIT_LOCK: pll_rst=0, sys_reset=1.
//     Stable counter increments on each cycle with locked_s=1 and clears on each cycle with locked_s=0.
//     When the stable count reaches LOCK_STABLE_CYCLES -> SYS_RESET.
//     Otherwise, when LOCK_TIMEOUT cycles have elapsed in this state -> PLL_RESET and lock_loss_cnt++.
//     If stable-reached and timeout occur in the same cycle, stable-reached wins.
// - SYS_RESET: pll_rst=0, sys_reset=1.
//     If locked_s=0 -> PLL_RESET and lock_loss_cnt++.
//     Otherwise, after SYS_RST_CYCLES cycles -> RUN.
// - RUN: sys_reset=0, running=1. If locked_s=0 for even a single cycle -> PLL_RESET and lock_loss_cnt++. There is no glitch filtering.
// - Latency from a pll_locked rise to sys_reset falling is exactly SYNC_STAGES+LOCK_STABLE_CYCLES+SYS_RST_CYCLES cycles.
// - Latency from a pll_locked fall in RUN to sys_reset rising (and pll_rst rising) is exactly SYNC_STAGES+1 cycles.
// - lock_loss_cnt saturates at 8'hFF and never wraps.
// - reset asserted in any state returns the block to its reset values on the next edge; an in-progress sequence is abandoned.
// - sys_reset is never low while pll_rst is high. running == !sys_reset at all times.
// STRUCTURE
// - Package pll_reset_pkg: state enum {PLL_RESET, WAIT_LOCK, SYS_RESET, RUN} and the lock_loss_cnt width constant.
// - Sub-module bit_sync: the parameterized SYNC_STAGES synchronizer for pll_locked.
// - Top level holds the FSM, the shared cycle counter, the stable counter and the saturating counter.
// TESTING (bench params: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT=50, SYS_RST_CYCLES=6, SYNC_STAGES=2)
// 1. Release reset with pll_locked=0 -> pll_rst high for exactly 4 cycles, then low; sys_reset stays 1; running stays 0.
// 2. Raise pll_locked at cycle T (in WAIT_LOCK) and hold it -> sys_reset falls at exactly T+16; running rises at the same edge; lock_loss_cnt=0.
// 3. Keep pll_locked=0 -> a 4-cycle pll_rst pulse repeats every 54 cycles; lock_loss_cnt increments on each retry.
// 4. Toggle pll_locked 1,1,1,0 repeatedly in WAIT_LOCK -> the 8-cycle stable count is never reached; sys_reset stays 1 until the timeout retry.
// 5. In RUN, drop pll_locked for 1 cycle -> sys_reset rises 3 cycles later; lock_loss_cnt=1; a full re-sequence then returns to RUN.
// 6. Force 300 timeouts -> lock_loss_cnt holds 8'hFF. Assert reset mid-SYS_RESET -> all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/pll_reset_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// State encoding, loss-counter width and small helpers used by pll_reset_ctrl.
package pll_reset_pkg;

  typedef enum logic [1:0] {
    PLL_RESET,
    WAIT_LOCK,
    SYS_RESET,
    RUN
  } state_e;

  localparam int unsigned LossCntW = 8;
  localparam logic [LossCntW-1:0] LossCntMax = '1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_reset_ctrl_bit_sync.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
// Flops clear under the synchronous reset so the sampled level starts at 0.
module bit_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic [Stages-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[Stages-2:0], i_d};
    end
  end

  assign o_q = r_sync[Stages-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, holds the
// system reset for a fixed window, then runs; any lock loss or timeout restarts.
module pll_reset_ctrl
  import pll_reset_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned LOCK_TIMEOUT       = 1000000,
  parameter int unsigned SYS_RST_CYCLES     = 64,
  parameter int unsigned SYNC_STAGES        = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_pll_locked,
  output logic                o_pll_rst,
  output logic                o_sys_reset,
  output logic                o_running,
  output logic [LossCntW-1:0] o_lock_loss_cnt
);

  localparam int unsigned MaxParam =
      max_u(max_u(PLL_RST_CYCLES, LOCK_STABLE_CYCLES), max_u(LOCK_TIMEOUT, SYS_RST_CYCLES));
  localparam int unsigned CntW    = $clog2(MaxParam + 1);
  localparam int unsigned StableW = $clog2(LOCK_STABLE_CYCLES + 1);

  state_e              r_state, w_state_d;
  logic [CntW-1:0]     r_cnt, w_cnt_d;
  logic [StableW-1:0]  r_stable, w_stable_d;
  logic [LossCntW-1:0] r_loss, w_loss_d;
  logic                r_pll_rst, r_sys_reset, r_running;
  logic                w_locked_s;
  logic                w_loss_inc;

  bit_sync #(
    .Stages(SYNC_STAGES)
  ) u_lock_sync (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_d    (i_pll_locked),
    .o_q    (w_locked_s)
  );

  always_comb begin
    w_state_d  = r_state;
    w_stable_d = '0;
    w_loss_inc = 1'b0;
    unique case (r_state)
      PLL_RESET: begin
        if (r_cnt == CntW'(PLL_RST_CYCLES - 1)) w_state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        w_stable_d = w_locked_s ? r_stable + StableW'(1) : '0;
        // Reaching the stable count takes priority over a coincident timeout.
        if (w_locked_s && (r_stable == StableW'(LOCK_STABLE_CYCLES - 1))) begin
          w_state_d = SYS_RESET;
        end else if (r_cnt == CntW'(LOCK_TIMEOUT - 1)) begin
          w_state_d  = PLL_RESET;
          w_loss_inc = 1'b1;
        end
      end
      SYS_RESET: begin
        if (!w_locked_s) begin
          w_state_d  = PLL_RESET;
          w_loss_inc = 1'b1;
        end else if (r_cnt == CntW'(SYS_RST_CYCLES - 1)) begin
          w_state_d = RUN;
        end
      end
      RUN: begin
        if (!w_locked_s) begin
          w_state_d  = PLL_RESET;
          w_loss_inc = 1'b1;
        end
      end
      default: w_state_d = PLL_RESET;
    endcase

    if (w_state_d != WAIT_LOCK || w_state_d != r_state) w_stable_d = '0;
    // The counter is idle in RUN, so park it at zero rather than let it wrap.
    w_cnt_d  = (w_state_d != r_state || r_state == RUN) ? '0 : r_cnt + CntW'(1);
    w_loss_d = (w_loss_inc && r_loss != LossCntMax) ? r_loss + LossCntW'(1) : r_loss;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= PLL_RESET;
      r_cnt       <= '0;
      r_stable    <= '0;
      r_loss      <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_reset <= 1'b1;
      r_running   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_stable    <= w_stable_d;
      r_loss      <= w_loss_d;
      r_pll_rst   <= (w_state_d == PLL_RESET);
      r_sys_reset <= (w_state_d != RUN);
      r_running   <= (w_state_d == RUN);
    end
  end

  assign o_pll_rst       = r_pll_rst;
  assign o_sys_reset     = r_sys_reset;
  assign o_running       = r_running;
  assign o_lock_loss_cnt = r_loss;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl: expected event cycles are queued when the
// stimulus is driven and compared when the DUT output edge is observed.
module tb_pll_reset_ctrl;

  localparam int unsigned PllRst = 4;
  localparam int unsigned Stable = 8;
  localparam int unsigned Tmo    = 50;
  localparam int unsigned SysRst = 6;
  localparam int unsigned Sync   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked;
  logic       pll_rst, sys_reset, running;
  logic [7:0] loss_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_cnt  = 0;

  typedef struct {
    string tag;
    int    cyc;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pll_reset_ctrl #(
    .PLL_RST_CYCLES    (PllRst),
    .LOCK_STABLE_CYCLES(Stable),
    .LOCK_TIMEOUT      (Tmo),
    .SYS_RST_CYCLES    (SysRst),
    .SYNC_STAGES       (Sync)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_pll_locked   (locked),
    .o_pll_rst      (pll_rst),
    .o_sys_reset    (sys_reset),
    .o_running      (running),
    .o_lock_loss_cnt(loss_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    chk("inv_rst_order", {31'b0, pll_rst & ~sys_reset}, 0);
    chk("inv_running", {31'b0, running ^ sys_reset}, 1);
  endtask

  task automatic push(input string tag, input int at);
    exp_t e;
    e.tag = tag;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  function automatic logic get_sig(input int sel);
    case (sel)
      0:       return pll_rst;
      1:       return sys_reset;
      default: return running;
    endcase
  endfunction

  // Wait (bounded) for the selected output to reach a level, then score it.
  task automatic await(input int sel, input logic level, input int budget, output int at);
    exp_t e;
    bit   found;
    found = 0;
    at    = -1;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (get_sig(sel) === level) begin
        found = 1;
        at    = cyc;
      end
    end
    e = exp_q.pop_front();
    chk(e.tag, at, e.cyc);
  endtask

  initial begin
    int t;
    int at;
    int w;
    bit found;

    rst    = 1'b1;
    locked = 1'b0;
    repeat (3) tick();
    chk("rst_pll_rst", {31'b0, pll_rst}, 1);
    chk("rst_sys_reset", {31'b0, sys_reset}, 1);
    chk("rst_running", {31'b0, running}, 0);
    chk("rst_loss_cnt", {24'b0, loss_cnt}, 0);

    // Reset release: PLL reset pulse of PllRst cycles counted from the reset edge.
    t   = cyc;
    rst = 1'b0;
    push("t1_pll_rst_fall", t + PllRst);
    await(0, 1'b0, 20, at);
    chk("t1_sys_reset", {31'b0, sys_reset}, 1);

    // Lock rise to release latency.
    repeat (3) tick();
    t      = cyc;
    locked = 1'b1;
    push("t2_sys_release", t + Sync + Stable + SysRst);
    await(1, 1'b0, 40, at);
    chk("t2_running", {31'b0, running}, 1);
    chk("t2_loss_cnt", {24'b0, loss_cnt}, exp_cnt);

    // One-cycle lock drop in RUN, then full re-sequence.
    repeat (4) tick();
    t      = cyc;
    locked = 1'b0;
    tick();
    locked = 1'b1;
    push("t5_sys_assert", t + Sync + 1);
    await(1, 1'b1, 10, at);
    exp_cnt++;
    chk("t5_pll_rst", {31'b0, pll_rst}, 1);
    chk("t5_loss_cnt", {24'b0, loss_cnt}, exp_cnt);
    push("t5_pll_rst_fall", t + Sync + 1 + PllRst);
    await(0, 1'b0, 10, at);
    push("t5_rerun", t + Sync + 1 + PllRst + Stable + SysRst);
    await(1, 1'b0, 30, at);
    chk("t5_running", {31'b0, running}, 1);

    // Lock held low: periodic timeout retries.
    t      = cyc;
    locked = 1'b0;
    push("t3_sys_assert", t + Sync + 1);
    await(1, 1'b1, 10, at);
    exp_cnt++;
    chk("t3_loss_cnt_drop", {24'b0, loss_cnt}, exp_cnt);
    push("t3_pll_rst_fall", t + Sync + 1 + PllRst);
    await(0, 1'b0, 10, w);
    for (int k = 0; k < 2; k++) begin
      push("t3_retry_rise", w + Tmo);
      await(0, 1'b1, Tmo + 10, at);
      exp_cnt++;
      chk("t3_loss_cnt", {24'b0, loss_cnt}, exp_cnt);
      push("t3_retry_fall", w + Tmo + PllRst);
      await(0, 1'b0, 10, w);
    end

    // Lock pattern 1,1,1,0 never accumulates the stable count.
    push("t4_retry_rise", w + Tmo);
    found = 0;
    at    = -1;
    for (int i = 0; i < Tmo + 10 && !found; i++) begin
      locked = ((i % 4) != 3);
      tick();
      if (pll_rst === 1'b1) begin
        found = 1;
        at    = cyc;
      end else begin
        chk("t4_sys_reset", {31'b0, sys_reset}, 1);
      end
    end
    begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.tag, at, e.cyc);
    end
    locked = 1'b0;
    exp_cnt++;
    chk("t4_loss_cnt", {24'b0, loss_cnt}, exp_cnt);
    push("t4_retry_fall", at + PllRst);
    await(0, 1'b0, 10, w);

    // Drive the loss counter well past saturation.
    for (int k = 0; k < 300; k++) begin
      push("t6_retry_rise", w + Tmo);
      await(0, 1'b1, Tmo + 10, at);
      if (exp_cnt < 255) exp_cnt++;
      push("t6_retry_fall", w + Tmo + PllRst);
      await(0, 1'b0, 10, w);
    end
    chk("t6_loss_sat", {24'b0, loss_cnt}, exp_cnt);

    // Reach SYS_RESET, then assert reset mid-window.
    locked = 1'b1;
    repeat (Sync + Stable + 2) tick();
    chk("t6_in_sysrst_pll", {31'b0, pll_rst}, 0);
    chk("t6_in_sysrst_sys", {31'b0, sys_reset}, 1);
    chk("t6_in_sysrst_loss", {24'b0, loss_cnt}, exp_cnt);
    rst = 1'b1;
    tick();
    chk("t6_rst_pll_rst", {31'b0, pll_rst}, 1);
    chk("t6_rst_sys_reset", {31'b0, sys_reset}, 1);
    chk("t6_rst_running", {31'b0, running}, 0);
    chk("t6_rst_loss_cnt", {24'b0, loss_cnt}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
